// File: rtl/mips32_prog_loader.sv
// rtl/mips32_prog_loader.sv - packs a byte stream into instruction words, loads them, then runs the core
// Optional trailing XOR checksum byte after HLT: define MIPS32_LOADER_CHECKSUM_EN.
module mips32_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  input  logic              core_halted,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_CKSUM, S_START, S_RUN, S_DONE, S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);

  state_t              state_q, state_d;
  logic [31:0]         word_q, word_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
`ifdef MIPS32_LOADER_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;
`endif

  logic is_hlt;
  assign is_hlt = (word_q[31:26] == 6'h3F);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      word_count_q <= '0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
`ifdef MIPS32_LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
`ifdef MIPS32_LOADER_CHECKSUM_EN
    xor_d        = xor_q;
`endif
    in_ready     = 1'b0;
    mem_we       = 1'b0;
    core_run     = 1'b0;
    done         = 1'b0;
    err          = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        done = (state_q == S_DONE);
        err  = (state_q == S_ERR);
        if (load_start) begin
          state_d      = S_LOAD;
          word_d       = '0;
          byte_cnt_d   = '0;
          addr_d       = '0;
          word_count_d = '0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
          xor_d        = '0;
`endif
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d     = {word_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef MIPS32_LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we       = 1'b1;
        word_count_d = word_count_q + {{ADDR_W{1'b0}}, 1'b1};
        byte_cnt_d   = '0;
        // Saturate at the last slot so the address never wraps to 0.
        if (addr_q != LAST_ADDR) addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (is_hlt) begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = S_START;
`endif
        end else if (addr_q == LAST_ADDR) begin
          state_d = S_ERR;
        end else begin
          state_d = S_LOAD;
        end
      end
`ifdef MIPS32_LOADER_CHECKSUM_EN
      S_CKSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (in_data == xor_q) ? S_START : S_ERR;
      end
`endif
      // core_halted is deliberately not looked at here; it may still be high from a previous run.
      S_START: state_d = S_RUN;
      S_RUN: begin
        core_run = 1'b1;
        if (core_halted) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = word_q;
  assign word_count = word_count_q;

endmodule
